// File: rtl/mult_div_unit_if.sv
// Start/operand/result bundle between the control unit and mult_div_unit.
interface mult_div_unit_if;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (output mult_start, div_start, a, b,
                    input  hi_out, lo_out, busy, done, div_zero);
    modport slave  (input  mult_start, div_start, a, b,
                    output hi_out, lo_out, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed mult/div unit holding HI/LO (Booth multiply, restoring divide).
// Define MULTDIV_FAST_MULT_EN for a single-cycle combinational multiply.
module mult_div_unit (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  mdu
);

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] opnd_q, opnd_d;     // multiplicand, or divisor magnitude
    logic [65:0] acc_q, acc_d;       // {upper33, lower32, q-1}; shared by mult and div
    logic        sa_q, sa_d, sb_q, sb_d;
    logic        dz_q, dz_d;

    // Divide step: upper holds the partial remainder, lower shifts dividend out / quotient in
    logic [32:0] rem_sh, diff;
    logic [65:0] div_nxt;

`ifdef MULTDIV_FAST_MULT_EN
    logic [63:0] prod;
`else
    // Upper part is 33 bits so adding/subtracting 0x80000000 cannot overflow
    logic [32:0] booth_sum;
    logic [65:0] booth_nxt;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = 1'b0;

        rem_sh  = {acc_q[64:33], acc_q[32]};
        diff    = rem_sh - {1'b0, opnd_q};
        div_nxt = diff[32] ? {rem_sh, acc_q[31:1], 1'b0, 1'b0}
                           : {diff,   acc_q[31:1], 1'b1, 1'b0};

`ifdef MULTDIV_FAST_MULT_EN
        prod = $signed(opnd_q) * $signed(acc_q[32:1]);
`else
        case (acc_q[1:0])
            2'b01:   booth_sum = acc_q[65:33] + {opnd_q[31], opnd_q};
            2'b10:   booth_sum = acc_q[65:33] - {opnd_q[31], opnd_q};
            default: booth_sum = acc_q[65:33];
        endcase
        booth_nxt = {booth_sum[32], booth_sum, acc_q[32:1]};
`endif

        case (state_q)
            S_IDLE: begin
                if (mdu.mult_start) begin
                    opnd_d  = mdu.a;
                    acc_d   = {33'd0, mdu.b, 1'b0};
                    cnt_d   = 5'd0;
                    state_d = S_MULT;
                end else if (mdu.div_start) begin
                    if (mdu.b != 32'd0) begin
                        opnd_d  = mdu.b[31] ? -mdu.b : mdu.b;
                        acc_d   = {33'd0, (mdu.a[31] ? -mdu.a : mdu.a), 1'b0};
                        sa_d    = mdu.a[31];
                        sb_d    = mdu.b[31];
                        cnt_d   = 5'd0;
                        state_d = S_DIV;
                    end else begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_MULT: begin
`ifdef MULTDIV_FAST_MULT_EN
                hi_d    = prod[63:32];
                lo_d    = prod[31:0];
                state_d = S_DONE;
`else
                acc_d = booth_nxt;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = booth_nxt[64:33];
                    lo_d    = booth_nxt[32:1];
                    state_d = S_DONE;
                end
`endif
            end
            S_DIV: begin
                acc_d = div_nxt;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                // Truncating division: quotient sign from sign mismatch, remainder follows dividend
                lo_d    = (sa_q ^ sb_q) ? -acc_q[32:1] : acc_q[32:1];
                hi_d    = sa_q ? -acc_q[64:33] : acc_q[64:33];
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            opnd_q  <= 32'd0;
            acc_q   <= 66'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
        end
    end

    assign mdu.hi_out   = hi_q;
    assign mdu.lo_out   = lo_q;
    assign mdu.busy     = (state_q != S_IDLE);
    assign mdu.done     = (state_q == S_DONE);
    assign mdu.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit; latency N means done is high at start edge + N.
module tb_mult_div_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef MULTDIV_FAST_MULT_EN
    localparam int MULT_LAT = 2;
`else
    localparam int MULT_LAT = 33;
`endif
    localparam int DIV_LAT = 34;

    mult_div_unit_if mdu_if ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue a start, then watch busy/done at each falling edge; optionally pulse mult_start mid-op.
    task automatic op(input logic ms, input logic ds, input logic [31:0] av, input logic [31:0] bv,
                      input int poke, output int lat, output logic bok, output logic dz);
        @(negedge clk);
        mdu_if.mult_start = ms;
        mdu_if.div_start  = ds;
        mdu_if.a          = av;
        mdu_if.b          = bv;
        @(negedge clk);
        mdu_if.mult_start = 1'b0;
        mdu_if.div_start  = 1'b0;
        lat = 0;
        bok = 1'b1;
        dz  = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (i == poke) begin
                mdu_if.mult_start = 1'b1;
                mdu_if.a = 32'd3;
                mdu_if.b = 32'd3;
            end else begin
                mdu_if.mult_start = 1'b0;
            end
            if (!mdu_if.busy) bok = 1'b0;
            if (mdu_if.done) begin
                lat = i;
                dz  = mdu_if.div_zero;
                break;
            end
            @(negedge clk);
        end
        mdu_if.mult_start = 1'b0;
    endtask

    initial begin
        int   lat;
        logic bok, dz, seen;

        reset = 1'b0;
        mdu_if.mult_start = 1'b0;
        mdu_if.div_start  = 1'b0;
        mdu_if.a = 32'd0;
        mdu_if.b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi",   mdu_if.hi_out,   0);
        chk("rst_lo",   mdu_if.lo_out,   0);
        chk("rst_busy", mdu_if.busy,     0);
        chk("rst_done", mdu_if.done,     0);
        chk("rst_dz",   mdu_if.div_zero, 0);
        reset = 1'b1;

        // 7 * -3 = -21
        op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, lat, bok, dz);
        chk("m1_lat",  lat, MULT_LAT);
        chk("m1_busy", bok, 1);
        chk("m1_hi",   mdu_if.hi_out, 32'hFFFF_FFFF);
        chk("m1_lo",   mdu_if.lo_out, 32'hFFFF_FFEB);
        chk("m1_dz",   dz, 0);
        @(negedge clk);
        chk("m1_idle_busy", mdu_if.busy, 0);
        chk("m1_idle_done", mdu_if.done, 0);

        // (-2^31)^2 = 2^62
        op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, bok, dz);
        chk("m2_lat", lat, MULT_LAT);
        chk("m2_hi",  mdu_if.hi_out, 32'h4000_0000);
        chk("m2_lo",  mdu_if.lo_out, 32'h0000_0000);

        // -7 / 2 -> q=-3, r=-1
        op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bok, dz);
        chk("d1_lat",  lat, DIV_LAT);
        chk("d1_busy", bok, 1);
        chk("d1_lo",   mdu_if.lo_out, 32'hFFFF_FFFD);
        chk("d1_hi",   mdu_if.hi_out, 32'hFFFF_FFFF);
        chk("d1_dz",   dz, 0);

        // Preload HI=0x12345678, LO=0 via (0x12345678*4) * 2^30
        op(1'b1, 1'b0, 32'h48D1_59E0, 32'h4000_0000, 0, lat, bok, dz);
        chk("pre_hi", mdu_if.hi_out, 32'h1234_5678);
        chk("pre_lo", mdu_if.lo_out, 32'h0000_0000);
        op(1'b0, 1'b1, 32'd5, 32'd0, 0, lat, bok, dz);
        chk("dz_lat", lat, 1);
        chk("dz_flag", dz, 1);
        chk("dz_hi",  mdu_if.hi_out, 32'h1234_5678);
        chk("dz_lo",  mdu_if.lo_out, 32'h0000_0000);
        @(negedge clk);
        chk("dz_pulse_end", mdu_if.div_zero, 0);

        // 0x80000000 / -1 wraps, with a stray mult_start in the middle
        op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5, lat, bok, dz);
        chk("ov_lat", lat, DIV_LAT);
        chk("ov_lo",  mdu_if.lo_out, 32'h8000_0000);
        chk("ov_hi",  mdu_if.hi_out, 32'h0000_0000);

        // Reset at cycle 10 of a multiply
        @(negedge clk);
        mdu_if.mult_start = 1'b1;
        mdu_if.a = 32'd7;
        mdu_if.b = 32'd9;
        @(negedge clk);
        mdu_if.mult_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rm_hi",   mdu_if.hi_out, 0);
        chk("rm_lo",   mdu_if.lo_out, 0);
        chk("rm_busy", mdu_if.busy,   0);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdu_if.done) seen = 1'b1;
        end
        chk("rm_nodone", seen, 0);

        // Both starts: multiply wins (6*7=42)
        op(1'b1, 1'b1, 32'd6, 32'd7, 0, lat, bok, dz);
        chk("both_lat", lat, MULT_LAT);
        chk("both_hi",  mdu_if.hi_out, 32'd0);
        chk("both_lo",  mdu_if.lo_out, 32'd42);
        chk("both_dz",  dz, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
